// File: rtl/interrupt_unit.sv
// Three-source prioritised interrupt controller: pending capture, global enable, service level, EPC.
// Define INT_NEST_EN to allow preemption by higher-priority sources using a 3-entry {EPC, LEVEL} stack.
module interrupt_unit #(
  parameter logic [31:0] VEC0 = 32'h0000_3000,
  parameter logic [31:0] VEC1 = 32'h0000_3100,
  parameter logic [31:0] VEC2 = 32'h0000_3200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  IRQ,
  input  logic        STI,
  input  logic        CLI,
  input  logic        ERET,
  input  logic [31:0] PC_NEXT,
  output logic        INT_TAKEN,
  output logic [31:0] INT_VECTOR,
  output logic [31:0] EPC,
  output logic        IE,
  output logic [1:0]  LEVEL,
  output logic [2:0]  PENDING
);

  logic [2:0]  r_irq_q;
  logic [2:0]  r_pending;
  logic        r_ie;
  logic [1:0]  r_level;
  logic [31:0] r_epc;

  logic [2:0]  w_rise;
  logic        w_sel_vld;
  logic [1:0]  w_sel_idx;
  logic [1:0]  w_sel_lvl;
  logic [31:0] w_vector;
  logic        w_lvl_ok;
  logic        w_take;
  logic        w_ret;
  logic [2:0]  w_take_mask;
  logic [2:0]  w_pending_nxt;

  // Source selection: highest set pending bit wins.
  always_comb begin
    w_sel_vld = |r_pending;
    w_sel_idx = 2'd0;
    if (r_pending[2]) begin
      w_sel_idx = 2'd2;
    end else if (r_pending[1]) begin
      w_sel_idx = 2'd1;
    end
  end

  always_comb begin
    w_vector = 32'h0;
    if (w_sel_vld) begin
      case (w_sel_idx)
        2'd2:    w_vector = VEC2;
        2'd1:    w_vector = VEC1;
        default: w_vector = VEC0;
      endcase
    end
  end

  assign w_sel_lvl = w_sel_idx + 2'd1;

`ifdef INT_NEST_EN
  assign w_lvl_ok = (w_sel_lvl > r_level);
`else
  assign w_lvl_ok = (r_level == 2'd0);
`endif

  assign w_take        = r_ie & w_sel_vld & ~ERET & w_lvl_ok;
  assign w_ret         = ERET & (r_level != 2'd0);
  assign w_rise        = IRQ & ~r_irq_q;
  assign w_take_mask   = w_take ? (3'b001 << w_sel_idx) : 3'b000;
  // A fresh rising edge on the source being taken keeps it pending.
  assign w_pending_nxt = (r_pending & ~w_take_mask) | w_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q   <= 3'b000;
      r_pending <= 3'b000;
      r_ie      <= 1'b0;
    end else begin
      r_irq_q   <= IRQ;
      r_pending <= w_pending_nxt;
      if (CLI) begin
        r_ie <= 1'b0;
      end else if (STI) begin
        r_ie <= 1'b1;
      end
    end
  end

`ifdef INT_NEST_EN
  logic [31:0] r_stk_epc [3];
  logic [1:0]  r_stk_lvl [3];
  logic [1:0]  r_sp;
  logic [1:0]  w_sp_top;

  assign w_sp_top = r_sp - 2'd1;

  // Each take pushes the interrupted context; levels only rise, so depth never exceeds 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 2'd0;
      r_epc   <= 32'h0;
      r_sp    <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_stk_epc[i] <= 32'h0;
        r_stk_lvl[i] <= 2'd0;
      end
    end else if (w_take) begin
      r_stk_epc[r_sp] <= r_epc;
      r_stk_lvl[r_sp] <= r_level;
      r_sp            <= r_sp + 2'd1;
      r_epc           <= PC_NEXT;
      r_level         <= w_sel_lvl;
    end else if (w_ret) begin
      r_epc   <= r_stk_epc[w_sp_top];
      r_level <= r_stk_lvl[w_sp_top];
      r_sp    <= w_sp_top;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 2'd0;
      r_epc   <= 32'h0;
    end else if (w_take) begin
      r_epc   <= PC_NEXT;
      r_level <= w_sel_lvl;
    end else if (w_ret) begin
      r_level <= 2'd0;
    end
  end
`endif

  assign INT_TAKEN  = w_take;
  assign INT_VECTOR = w_vector;
  assign EPC        = r_epc;
  assign IE         = r_ie;
  assign LEVEL      = r_level;
  assign PENDING    = r_pending;

endmodule

// File: tb/tb_interrupt_unit.sv
// Bench for interrupt_unit: directed vector table, corner-case sequences, and random traffic
// checked against a queue-based reference model.
module tb_interrupt_unit;

  localparam logic [31:0] V0 = 32'h0000_3000;
  localparam logic [31:0] V1 = 32'h0000_3100;
  localparam logic [31:0] V2 = 32'h0000_3200;

`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
  localparam logic [31:0] E1 = 32'h0, E2 = 32'h0, E3 = 32'h0;
`else
  localparam bit NEST = 1'b0;
  localparam logic [31:0] E1 = 32'h40, E2 = 32'h50, E3 = 32'h70;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  IRQ;
  logic        STI, CLI, ERET;
  logic [31:0] PC_NEXT;
  logic        INT_TAKEN;
  logic [31:0] INT_VECTOR, EPC;
  logic        IE;
  logic [1:0]  LEVEL;
  logic [2:0]  PENDING;

  interrupt_unit #(.VEC0(V0), .VEC1(V1), .VEC2(V2)) dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .STI(STI), .CLI(CLI), .ERET(ERET),
    .PC_NEXT(PC_NEXT), .INT_TAKEN(INT_TAKEN), .INT_VECTOR(INT_VECTOR),
    .EPC(EPC), .IE(IE), .LEVEL(LEVEL), .PENDING(PENDING)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending as a bit array, service context as a queue of {epc, level}.
  typedef struct { logic [31:0] epc; int lvl; } ctx_t;
  bit    m_pend [3];
  bit    m_prev [3];
  bit    m_ie;
  int    m_lvl;
  logic [31:0] m_epc;
  ctx_t  m_stack [$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
    m_ie = 0; m_lvl = 0; m_epc = 32'h0;
    m_stack.delete();
  endtask

  function automatic int model_sel();
    int s = -1;
    for (int i = 0; i < 3; i++) if (m_pend[i]) s = i;
    return s;
  endfunction

  function automatic logic [31:0] model_vec(input int s);
    logic [31:0] tbl [3];
    tbl[0] = V0; tbl[1] = V1; tbl[2] = V2;
    return (s < 0) ? 32'h0 : tbl[s];
  endfunction

  function automatic logic [2:0] model_pend_vec();
    return {m_pend[2], m_pend[1], m_pend[0]};
  endfunction

  // Drive one cycle, compare all outputs with the model, then advance the model past the edge.
  task automatic step(input logic [2:0] irq, input logic sti, input logic cli,
                      input logic eret, input logic [31:0] pc);
    int  s;
    bit  tk;
    ctx_t c;
    @(negedge clk);
    IRQ = irq; STI = sti; CLI = cli; ERET = eret; PC_NEXT = pc;
    #1;
    s  = model_sel();
    tk = m_ie && (s >= 0) && !eret && (s + 1 > m_lvl) && (NEST || m_lvl == 0);
    chk("m_taken",   {31'h0, INT_TAKEN}, {31'h0, tk});
    chk("m_vector",  INT_VECTOR, model_vec(s));
    chk("m_epc",     EPC, m_epc);
    chk("m_ie",      {31'h0, IE}, {31'h0, m_ie});
    chk("m_level",   {30'h0, LEVEL}, m_lvl);
    chk("m_pending", {29'h0, PENDING}, {29'h0, model_pend_vec()});
    for (int i = 0; i < 3; i++) begin
      bit rose = irq[i] && !m_prev[i];
      if (tk && s == i) m_pend[i] = rose;
      else              m_pend[i] = m_pend[i] || rose;
      m_prev[i] = irq[i];
    end
    if (tk) begin
      if (NEST) begin c.epc = m_epc; c.lvl = m_lvl; m_stack.push_back(c); end
      m_epc = pc;
      m_lvl = s + 1;
    end else if (eret && m_lvl != 0) begin
      if (NEST) begin c = m_stack.pop_back(); m_epc = c.epc; m_lvl = c.lvl; end
      else m_lvl = 0;
    end
    if (cli) m_ie = 0;
    else if (sti) m_ie = 1;
  endtask

  typedef struct {
    logic [2:0]  irq;
    logic        sti, cli, eret;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] vec, epc;
    logic        ie;
    logic [1:0]  lvl;
    logic [2:0]  pend;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] irq, input logic sti, input logic cli,
                              input logic eret, input logic [31:0] pc, input logic taken,
                              input logic [31:0] vec, input logic [31:0] epc, input logic ie,
                              input logic [1:0] lvl, input logic [2:0] pend);
    vec_t v;
    v.irq = irq; v.sti = sti; v.cli = cli; v.eret = eret; v.pc = pc;
    v.taken = taken; v.vec = vec; v.epc = epc; v.ie = ie; v.lvl = lvl; v.pend = pend;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    // Each row: inputs for the cycle, then outputs expected during that same cycle.
    tbl[0]  = mk(3'b000, 0, 0, 0, 32'h00, 0, 32'h0, 32'h0, 0, 0, 3'b000);
    tbl[1]  = mk(3'b000, 1, 0, 0, 32'h00, 0, 32'h0, 32'h0, 0, 0, 3'b000);
    tbl[2]  = mk(3'b010, 0, 0, 0, 32'h00, 0, 32'h0, 32'h0, 1, 0, 3'b000);
    tbl[3]  = mk(3'b010, 0, 0, 0, 32'h40, 1, V1,    32'h0, 1, 0, 3'b010);
    tbl[4]  = mk(3'b000, 0, 0, 0, 32'h44, 0, 32'h0, 32'h40, 1, 2, 3'b000);
    tbl[5]  = mk(3'b000, 0, 0, 1, 32'h44, 0, 32'h0, 32'h40, 1, 2, 3'b000);
    tbl[6]  = mk(3'b000, 0, 1, 0, 32'h44, 0, 32'h0, E1,    1, 0, 3'b000);
    tbl[7]  = mk(3'b101, 0, 0, 0, 32'h44, 0, 32'h0, E1,    0, 0, 3'b000);
    tbl[8]  = mk(3'b101, 0, 0, 0, 32'h44, 0, V2,    E1,    0, 0, 3'b101);
    tbl[9]  = mk(3'b000, 1, 0, 0, 32'h48, 0, V2,    E1,    0, 0, 3'b101);
    tbl[10] = mk(3'b000, 0, 0, 0, 32'h50, 1, V2,    E1,    1, 0, 3'b101);
    tbl[11] = mk(3'b000, 0, 0, 0, 32'h54, 0, V0,    32'h50, 1, 3, 3'b001);
    tbl[12] = mk(3'b000, 0, 0, 1, 32'h60, 0, V0,    32'h50, 1, 3, 3'b001);
    tbl[13] = mk(3'b000, 0, 0, 0, 32'h70, 1, V0,    E2,    1, 0, 3'b001);
    tbl[14] = mk(3'b000, 1, 1, 0, 32'h74, 0, 32'h0, 32'h70, 1, 1, 3'b000);
    tbl[15] = mk(3'b000, 0, 0, 1, 32'h74, 0, 32'h0, 32'h70, 0, 1, 3'b000);
    tbl[16] = mk(3'b000, 0, 0, 1, 32'h78, 0, 32'h0, E3,    0, 0, 3'b000);
    tbl[17] = mk(3'b000, 0, 0, 0, 32'h7c, 0, 32'h0, E3,    0, 0, 3'b000);

    rst = 1'b1; IRQ = 3'b000; STI = 0; CLI = 0; ERET = 0; PC_NEXT = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_taken",   {31'h0, INT_TAKEN}, 32'h0);
    chk("rst_epc",     EPC, 32'h0);
    chk("rst_ie",      {31'h0, IE}, 32'h0);
    chk("rst_level",   {30'h0, LEVEL}, 32'h0);
    chk("rst_pending", {29'h0, PENDING}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 18; r++) begin
      step(tbl[r].irq, tbl[r].sti, tbl[r].cli, tbl[r].eret, tbl[r].pc);
      chk($sformatf("tbl%0d_taken", r), {31'h0, INT_TAKEN}, {31'h0, tbl[r].taken});
      chk($sformatf("tbl%0d_vec", r), INT_VECTOR, tbl[r].vec);
      chk($sformatf("tbl%0d_epc", r), EPC, tbl[r].epc);
      chk($sformatf("tbl%0d_ie", r), {31'h0, IE}, {31'h0, tbl[r].ie});
      chk($sformatf("tbl%0d_lvl", r), {30'h0, LEVEL}, {30'h0, tbl[r].lvl});
      chk($sformatf("tbl%0d_pend", r), {29'h0, PENDING}, {29'h0, tbl[r].pend});
    end

    // Higher-priority request arriving while IRQ[0] is in service.
    step(3'b001, 1, 0, 0, 32'h10);
    step(3'b001, 0, 0, 0, 32'h20);
    step(3'b100, 0, 0, 0, 32'h88);
    step(3'b100, 0, 0, 0, 32'h88);
    chk("nest_take", {31'h0, INT_TAKEN}, {31'h0, NEST});
    step(3'b000, 0, 0, 0, 32'h8c);
    chk("nest_epc", EPC, NEST ? 32'h88 : 32'h20);
    chk("nest_lvl", {30'h0, LEVEL}, NEST ? 32'd3 : 32'd1);
    step(3'b000, 0, 0, 1, 32'h8c);
    step(3'b000, 0, 0, 1, 32'h8c);
    chk("nest_ret_epc", EPC, 32'h20);
    step(3'b000, 0, 0, 0, 32'h90);
    chk("nest_ret_lvl", {30'h0, LEVEL}, 32'd0);
    step(3'b000, 0, 0, 0, 32'h94);

    // Drain service context with IE off.
    step(3'b000, 0, 1, 1, 32'h0);
    repeat (3) step(3'b000, 0, 0, 1, 32'h0);

    // New edge on the source being taken keeps it pending.
    step(3'b001, 0, 0, 0, 32'h100);
    step(3'b000, 1, 0, 0, 32'h104);
    step(3'b001, 0, 0, 0, 32'h108);
    chk("win_taken", {31'h0, INT_TAKEN}, 32'h1);
    step(3'b001, 0, 0, 0, 32'h10c);
    chk("win_pend0", {31'h0, PENDING[0]}, 32'h1);
    chk("win_lvl", {30'h0, LEVEL}, 32'd1);

    // Build LEVEL=2 with PENDING=001, then reset between clock edges.
    step(3'b000, 0, 1, 1, 32'h110);
    step(3'b010, 1, 0, 0, 32'h114);
    step(3'b000, 0, 0, 0, 32'h118);
    step(3'b000, 0, 0, 0, 32'h11c);
    chk("pre_rst_lvl", {30'h0, LEVEL}, 32'd2);
    chk("pre_rst_pend", {29'h0, PENDING}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_taken", {31'h0, INT_TAKEN}, 32'h0);
    chk("arst_vec",   INT_VECTOR, 32'h0);
    chk("arst_epc",   EPC, 32'h0);
    chk("arst_ie",    {31'h0, IE}, 32'h0);
    chk("arst_lvl",   {30'h0, LEVEL}, 32'h0);
    chk("arst_pend",  {29'h0, PENDING}, 32'h0);
    IRQ = 3'b000; STI = 0; CLI = 0; ERET = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random traffic against the model.
    begin
      logic [2:0] irq_r = 3'b000;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 2) == 0) irq_r = 3'($urandom_range(0, 7));
        step(irq_r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 4) == 0), {$urandom} & 32'hffff_fffc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
